gouram_trace_serialiser: RTL and testbench
==========================================

Name: gouram_trace_serialiser

Overview:
- Sits directly downstream of the gouram trace unit.
- Captures each 128-bit trace record on the unit's capture strobe and buffers it in a small record FIFO.
- Drains each record as four 32-bit beats on a valid/ready stream toward the host-side trace sink.
- Counts records dropped because the FIFO was full, so trace loss is visible to software.

Parameters:
FIFO_DEPTH, 4, number of 128-bit records buffered; power of two, >= 2
DROP_CNT_WIDTH, 16, width of the saturating dropped-record counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
trace_data_i  input  128  trace record from gouram trace_data_o
trace_valid_i  input  1  capture strobe from gouram trace_capture_enable; one record per high cycle
m_tdata  output  32  stream data beat
m_tvalid  output  1  stream beat valid
m_tready  input  1  stream sink ready
m_tlast  output  1  high on the final (4th) beat of a record
fifo_level  output  $clog2(FIFO_DEPTH)+1  records currently held, including the one being drained
overflow  output  1  sticky; set when any record is dropped
drop_count  output  DROP_CNT_WIDTH  saturating count of dropped records

Behaviour:
- Reset:
  - Sampled only on a rising clk edge with rst=1.
  - Clears the FIFO pointers, level, beat counter, overflow and drop_count.
  - After the reset edge: m_tvalid=0, m_tlast=0, m_tdata=0, fifo_level=0, overflow=0, drop_count=0.
  - Reset mid-record discards the partial record and all buffered records; no further beats of it are emitted.
- Write:
  - On a clk edge with trace_valid_i=1 and the FIFO not full after this cycle's pop, trace_data_i is stored at the write pointer.
  - The write pointer increments modulo FIFO_DEPTH.
- Full:
  - full means fifo_level==FIFO_DEPTH.
  - Pop-then-push: if the last beat of the head record handshakes in the same cycle as a write while full, the write is accepted and fifo_level stays at FIFO_DEPTH.
- Drop:
  - Occurs when trace_valid_i=1, the FIFO is full and no final-beat pop happens that cycle.
  - The record is discarded, overflow<=1, and drop_count increments.
  - drop_count saturates at 2^DROP_CNT_WIDTH-1.
- Latency:
  - A record written into an empty FIFO on edge N gives m_tvalid=1 from the cycle after edge N.
  - The first beat is visible one cycle after capture; there is no combinational path from trace_valid_i to m_tvalid.
- Beat sequencing:
  - A 2-bit beat counter selects m_tdata = head[32*beat +: 32].
  - Beat 0 is bits [31:0], beat 3 is bits [127:96], least significant word first.
  - m_tlast = m_tvalid && beat==3.
- Handshake:
  - A beat transfers on an edge where m_tvalid && m_tready.
  - While m_tvalid=1 && m_tready=0, m_tdata and m_tlast hold stable and m_tvalid stays high.
  - m_tvalid never depends combinationally on m_tready.
- Pop:
  - Transfer of beat 3 advances the read pointer modulo FIFO_DEPTH, resets beat to 0 and decrements fifo_level, unless a write happens in the same cycle.
- Back-to-back drain:
  - If another record is held, m_tvalid remains high and beat 0 of the next record is presented in the cycle after the beat-3 transfer.
  - Sustained throughput is one beat per cycle.
- Empty: fifo_level==0 gives m_tvalid=0; m_tdata is don't-care but is held at its last value.
- Level arithmetic: fifo_level next = level + push - pop, with push and pop each 0/1; it never exceeds FIFO_DEPTH or underflows.

Test Plan:
- Single record: reset, then one strobe with data 0x44444444_33333333_22222222_11111111 and m_tready=1.
  - m_tvalid rises the next cycle.
  - Beats are 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles, with m_tlast only on the 4th.
  - fifo_level goes 1 then 0.
- Backpressure: same record, m_tready low for 5 cycles after the 2nd beat appears.
  - m_tdata holds 0x22222222 with m_tvalid=1 throughout.
  - Draining resumes in order when m_tready returns to 1.
- Overflow: m_tready=0, 6 consecutive strobes with FIFO_DEPTH=4.
  - fifo_level=4, drop_count=2, overflow=1.
  - When later drained, the first 4 records appear in order.
- Simultaneous push/pop when full: FIFO full, strobe in the same cycle as the beat-3 handshake.
  - Record is accepted and fifo_level stays at 4.
  - drop_count is unchanged.
  - The new record is emitted last.
- Saturation: DROP_CNT_WIDTH=2, FIFO full, 5 strobes with no drain.
  - drop_count goes 1,2,3,3,3.
- Reset mid-record: assert rst for 1 cycle after beat 1 of a 3-record backlog.
  - Next cycle: m_tvalid=0, fifo_level=0, overflow=0.
  - A subsequent strobe drains from beat 0 correctly.

Source files
------------

// File: rtl/gouram_trace_serialiser.sv
// Buffers 128-bit gouram trace records in a small FIFO and drains each one as
// four 32-bit valid/ready beats, least significant word first; full-FIFO drops are counted.
module gouram_trace_serialiser #(
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [127:0]                  trace_data_i,
  input  logic                          trace_valid_i,
  output logic [31:0]                   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [127:0]              mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [LW-1:0]             level;
  logic [1:0]                beat;
  logic [31:0]               last_data;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;
  logic                      ovf;

  logic [127:0] head;
  logic [31:0]  head_word;
  logic         full;
  logic         xfer;
  logic         pop;
  logic         push;
  logic         drop;

  assign head = mem[rd_ptr];

  always_comb begin
    head_word = head[31:0];
    case (beat)
      2'd0: head_word = head[31:0];
      2'd1: head_word = head[63:32];
      2'd2: head_word = head[95:64];
      2'd3: head_word = head[127:96];
      default: head_word = head[31:0];
    endcase
  end

  // Valid comes purely from registered level, so there is no path from trace_valid_i or m_tready.
  assign m_tvalid = (level != '0);
  assign m_tdata  = m_tvalid ? head_word : last_data;
  assign m_tlast  = m_tvalid && (beat == 2'd3);

  assign full = (level == LW'(FIFO_DEPTH));
  assign xfer = m_tvalid && m_tready;
  assign pop  = xfer && (beat == 2'd3);
  assign push = trace_valid_i && (!full || pop);
  assign drop = trace_valid_i && full && !pop;

  assign fifo_level = level;
  assign overflow   = ovf;
  assign drop_count = drop_cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= trace_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      beat      <= '0;
      last_data <= '0;
      drop_cnt  <= '0;
      ovf       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
      // Remember the last presented word so the data bus holds steady once empty.
      if (xfer) begin
        last_data <= head_word;
        beat      <= beat + 2'd1;
      end
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_gouram_trace_serialiser.sv
// Bench for gouram_trace_serialiser: directed scenarios plus random traffic,
// all checked every cycle against a queue-based record model.
module tb_gouram_trace_serialiser;

  localparam int DEPTH = 4;
  localparam int DW    = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] trace_data_i;
  logic         trace_valid_i;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [$clog2(DEPTH):0] fifo_level;
  logic         overflow;
  logic [DW-1:0] drop_count;

  gouram_trace_serialiser #(.FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .trace_data_i  (trace_data_i),
    .trace_valid_i (trace_valid_i),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tlast       (m_tlast),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [127:0] q[$];
  int           beat_m;
  logic [31:0]  last_m;
  int           drops_m;
  bit           ovf_m;

  localparam logic [127:0] REC = 128'h44444444_33333333_22222222_11111111;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    q.delete();
    beat_m  = 0;
    last_m  = '0;
    drops_m = 0;
    ovf_m   = 1'b0;
  endtask

  function automatic logic [127:0] rand_rec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input bit v, input logic [127:0] d, input bit r);
    bit ev, xfer, pop, full;
    logic [31:0]  ed;
    logic [127:0] h;
    trace_valid_i = v;
    trace_data_i  = d;
    m_tready      = r;
    @(negedge clk);
    ev = (q.size() != 0);
    if (ev) begin
      h  = q[0];
      ed = h[beat_m*32 +: 32];
    end else begin
      ed = last_m;
    end
    chk("tvalid", m_tvalid, ev);
    chk("tdata", m_tdata, ed);
    chk("tlast", m_tlast, ev && beat_m == 3);
    chk("level", fifo_level, q.size());
    chk("overflow", overflow, ovf_m);
    chk("drop_count", drop_count, drops_m);
    full = (q.size() == DEPTH);
    xfer = ev && r;
    pop  = xfer && beat_m == 3;
    if (xfer) begin
      last_m = ed;
      beat_m++;
    end
    if (pop) begin
      void'(q.pop_front());
      beat_m = 0;
    end
    if (v) begin
      if (!full || pop) q.push_back(d);
      else begin
        ovf_m = 1'b1;
        if (drops_m < (2**DW) - 1) drops_m++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    trace_valid_i = 1'b0;
    trace_data_i  = '0;
    m_tready      = 1'b0;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    trace_valid_i = 1'b0;
    trace_data_i = '0;
    m_tready = 1'b0;
    model_reset();
    do_reset();

    // Single record
    cycle(1'b1, REC, 1'b1);
    drain(6);

    // Backpressure on the second beat
    cycle(1'b1, REC, 1'b1);
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0);
    drain(6);

    // Overflow: six strobes into a stalled FIFO
    for (int i = 0; i < 6; i++) cycle(1'b1, rand_rec(), 1'b0);
    cycle(1'b0, '0, 1'b0);
    drain(20);

    // Pop-then-push while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_rec(), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, rand_rec(), 1'b1);
    cycle(1'b0, '0, 1'b0);
    drain(20);

    // Saturation of the 2-bit drop counter
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_rec(), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_rec(), 1'b0);
    cycle(1'b0, '0, 1'b0);

    // Reset mid-record with a three-record backlog
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_rec(), 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    do_reset();
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, REC, 1'b1);
    drain(6);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle($urandom_range(0, 99) < 40, rand_rec(), $urandom_range(0, 99) < 60);
    end
    drain(24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
